// File: rtl/muxn_pipe.sv
// N_IN:1 binary mux tree with a registered valid/ready pipeline.
// A register stage sits after every REG_EVERY tree levels.
module muxn_pipe #(
  parameter int N_IN      = 4,
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_IN*WIDTH-1:0]     i_i,
  input  logic [$clog2(N_IN)-1:0]   s_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [WIDTH-1:0]          y_o,
  output logic                      err_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int SEL_W  = LEVELS;
  localparam int LAT    = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int NP     = 1 << LEVELS;
  localparam int DW     = NP * WIDTH;
  localparam logic [SEL_W:0] NIN_C = (SEL_W+1)'(N_IN);

  logic [DW-1:0]  w_leaf;
  logic           w_err;
  logic [LAT-1:0] w_vld;
  logic [LAT-1:0] w_adv;

  assign w_err = {1'b0, s_i} >= NIN_C;

  // Out-of-range selects flush every leaf so they cannot alias.
  always_comb begin
    w_leaf = '0;
    w_leaf[N_IN*WIDTH-1:0] = i_i;
    if (w_err) w_leaf = '0;
  end

  always_comb begin
    w_adv = '0;
    w_adv[LAT-1] = !w_vld[LAT-1] || ready_i;
    for (int k = LAT - 2; k >= 0; k--) begin
      w_adv[k] = !w_vld[k] || w_adv[k+1];
    end
  end

  assign ready_o = w_adv[0];

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    logic [DW-1:0]    w_src;
    logic [DW-1:0]    w_res;
    logic [SEL_W-1:0] w_sel;

    if (j == 0) begin : g_in
      assign w_src = w_leaf;
      assign w_sel = s_i;
    end else if (j % REG_EVERY == 0) begin : g_reg
      assign w_src = g_stg[j/REG_EVERY-1].r_data;
      assign w_sel = g_stg[j/REG_EVERY-1].r_sel;
    end else begin : g_cmb
      assign w_src = g_lvl[j-1].w_res;
      assign w_sel = g_lvl[j-1].w_sel;
    end

    always_comb begin
      w_res = '0;
      for (int m = 0; m < (NP >> (j + 1)); m++) begin
        w_res[m*WIDTH +: WIDTH] = w_sel[j]
          ? w_src[(2*m+1)*WIDTH +: WIDTH]
          : w_src[(2*m)*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int KE = (k + 1) * REG_EVERY;
    localparam int KL = (KE > LEVELS ? LEVELS : KE) - 1;

    logic             r_vld;
    logic             r_err;
    logic [DW-1:0]    r_data;
    logic [SEL_W-1:0] r_sel;
    logic             w_iv;
    logic             w_ie;

    if (k == 0) begin : g_first
      assign w_iv = valid_i;
      assign w_ie = w_err;
    end else begin : g_next
      assign w_iv = g_stg[k-1].r_vld;
      assign w_ie = g_stg[k-1].r_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld  <= 1'b0;
        r_err  <= 1'b0;
        r_data <= '0;
        r_sel  <= '0;
      end else if (w_adv[k]) begin
        r_vld <= w_iv;
        if (w_iv) begin
          r_data <= g_lvl[KL].w_res;
          r_sel  <= g_lvl[KL].w_sel;
          r_err  <= w_ie;
        end
      end
    end

    assign w_vld[k] = r_vld;
  end

  assign valid_o = g_stg[LAT-1].r_vld;
  assign y_o     = valid_o ? g_stg[LAT-1].r_data[WIDTH-1:0] : '0;
  assign err_o   = valid_o & g_stg[LAT-1].r_err;

endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of data inputs; legal range 2..64.
REQ-002 SHALL have parameter WIDTH, default 8, bits per data input; legal range 1 or more.
REQ-003 SHALL have parameter REG_EVERY, default 1, number of mux tree levels between pipeline registers; legal range 1..LEVELS.
REQ-004 SHALL derive the following values:
- LEVELS = clog2(N_IN)
- SEL_W = LEVELS
- LAT = ceil(LEVELS / REG_EVERY)
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_i, input, N_IN*WIDTH bits: data inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port s_i, input, SEL_W bits: select index, captured with the beat.
REQ-009 SHALL have port valid_i, input, 1 bit: upstream beat valid.
REQ-010 SHALL have port ready_o, output, 1 bit: the block accepts a beat this cycle.
REQ-011 SHALL have port y_o, output, WIDTH bits: selected data.
REQ-012 SHALL have port err_o, output, 1 bit: the beat on y_o carried s_i >= N_IN.
REQ-013 SHALL have port valid_o, output, 1 bit: the beat on y_o is valid.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts the beat.

Function
REQ-015 SHALL realise the N_IN:1 selection as a binary tree of 2:1 muxes with LEVELS levels; tree level j is steered by select bit s[j] (LSB at the input-side level).
REQ-016 SHALL insert a pipeline register after every REG_EVERY tree levels and after the last level; total register stages = LAT.
REQ-017 SHALL give each register stage a valid bit; the stage holds the partial mux results, the remaining select bits, and the err flag.
REQ-018 SHALL, for a beat transferred on valid_i and ready_o both high in cycle t, present that beat on y_o/valid_o in cycle t+LAT when downstream is not stalled.
REQ-019 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances when valid_o is low or ready_i is high.
REQ-020 SHALL drive ready_o as the advance condition of stage 0, combinationally; no combinational path from valid_i to ready_o.
REQ-021 SHALL hold a stalled stage's data, select and err stable until it advances; y_o and err_o SHALL stay stable while valid_o is high and ready_i is low.
REQ-022 SHALL sustain one beat per cycle with ready_i held high, with no bubbles inserted.
REQ-023 SHALL, for s_i >= N_IN, output y_o = 0 with err_o = 1 for that beat; the out-of-range select SHALL NOT alias to any real input.
REQ-024 SHALL treat nonexistent tree leaves (N_IN not a power of two) as zero.
REQ-025 SHALL drive y_o = 0 and err_o = 0 whenever valid_o is low.
REQ-026 SHALL sample i_i only on accepted beats; a change on i_i after acceptance SHALL NOT affect in-flight beats.
REQ-027 SHALL, when N_IN = 2, have LAT = 1 and a single stage.

Reset
REQ-028 SHALL, while rst_ni is low, asynchronously clear all stage valid bits, data, select and err registers to 0.
REQ-029 SHALL hold the following outputs during reset:
- valid_o = 0
- y_o = 0
- err_o = 0
- ready_o = 1
REQ-030 SHALL discard in-flight beats on mid-operation reset; none SHALL appear after release.
REQ-031 SHALL accept a beat on the first rising edge after rst_ni deasserts.

Verification
REQ-032 SHALL be verified by a directed test with N_IN=4, WIDTH=8, REG_EVERY=1: i_i = {0x44,0x33,0x22,0x11}, s_i = 0,1,2,3 on consecutive cycles with ready_i=1 -> y_o = 0x11,0x22,0x33,0x44 on cycles t+2..t+5, with valid_o continuously high.
REQ-033 SHALL be verified by a directed test with N_IN=3: s_i=3 with i_i = {0xAA,0xBB,0xCC} -> y_o=0, err_o=1 after LAT cycles; s_i=2 -> y_o=0xAA, err_o=0.
REQ-034 SHALL be verified by a directed backpressure test with N_IN=4, REG_EVERY=1: ready_i=0 for 5 cycles while feeding beats -> ready_o falls once both stages are full, y_o is held constant, and no beat is lost or duplicated after ready_i returns to 1.
REQ-035 SHALL be verified by a directed test with N_IN=8, REG_EVERY=3: latency is 1 cycle and s_i=5 selects input 5.
REQ-036 SHALL be verified by a directed test with N_IN=8, REG_EVERY=1: assert rst_ni low with 3 beats in flight -> valid_o=0 and y_o=0 immediately (asynchronous); after release, no stale beat emerges.
